// File: rtl/spi_pkg.sv
// Shared types and elaboration helpers for the SPI master controller.
package spi_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      XFER,
      HOLD
   } spi_state_t;

   typedef struct packed {
      logic cpol;
      logic cpha;
      logic lsb_first;
   } spi_mode_t;

   function automatic int beat_count(input int word_w, input int lane_w);
      return word_w / lane_w;
   endfunction

   // A single slave still gets a 1-bit index so the port never collapses to zero width.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period counter and SCLK toggle; tick every div+1 cycles after a load,
// lead/trail strobes flag the coming toggle away from / back to CPOL.
module spi_clk_gen #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [DIV_WIDTH-1:0] div,
   input  logic                 run,
   input  logic                 park,
   input  logic                 idle_lvl,
   input  logic                 cpol,
   output logic                 tick,
   output logic                 lead_edge,
   output logic                 trail_edge,
   output logic                 sclk
);

   logic [DIV_WIDTH-1:0] cnt;

   assign tick       = !load && (cnt == '0);
   assign lead_edge  = run && tick && (sclk == cpol);
   assign trail_edge = run && tick && (sclk != cpol);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt  <= '0;
         sclk <= 1'b0;
      end else begin
         if (load || tick) cnt <= div;
         else              cnt <= cnt - 1'b1;

         if (park)             sclk <= idle_lvl;
         else if (run && tick) sclk <= ~sclk;
      end
   end

endmodule

// File: rtl/tree_decoder.sv
// Binary index to one-hot select; out-of-range or disabled gives all-zero.
module tree_decoder #(
   parameter int SEL_WIDTH = 1,
   parameter int OUT_WIDTH = 2
) (
   input  logic                 en,
   input  logic [SEL_WIDTH-1:0] sel,
   output logic [OUT_WIDTH-1:0] dec
);

   always_comb begin
      dec = '0;
      for (int i = 0; i < OUT_WIDTH; i++) begin
         if (en && (sel == SEL_WIDTH'(i))) dec[i] = 1'b1;
      end
   end

endmodule

// File: rtl/spi_master_ctrl.sv
// Synchronous SPI master: done_o pulses (2N+2)*(div+1) cycles after accept.
// start_ready_o only in IDLE; abort_i drops any active transfer without done_o.
module spi_master_ctrl
   import spi_pkg::*;
#(
   parameter int WORD_WIDTH = 8,
   parameter int LANE_WIDTH = 1,
   parameter int SS_WIDTH   = 1,
   parameter int DIV_WIDTH  = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start_valid_i,
   output logic                             start_ready_o,
   input  logic [WORD_WIDTH-1:0]            tx_data_i,
   input  logic [sel_width(SS_WIDTH)-1:0]   ss_sel_i,
   input  logic                             cpol_i,
   input  logic                             cpha_i,
   input  logic                             lsb_first_i,
   input  logic [DIV_WIDTH-1:0]             div_i,
   input  logic                             abort_i,
   output logic [WORD_WIDTH-1:0]            rx_data_o,
   output logic                             done_o,
   output logic                             busy_o,
   output logic                             sclk_o,
   output logic [SS_WIDTH-1:0]              ss_o,
   output logic [LANE_WIDTH-1:0]            sd_o,
   input  logic [LANE_WIDTH-1:0]            sd_i
);

   localparam int N  = beat_count(WORD_WIDTH, LANE_WIDTH);
   localparam int CW = $clog2(2 * N + 1);
   localparam int SW = sel_width(SS_WIDTH);

   generate
      if (WORD_WIDTH % LANE_WIDTH != 0) begin : g_width_chk
         $error("spi_master_ctrl: WORD_WIDTH must be a multiple of LANE_WIDTH");
      end
   endgenerate

   spi_state_t            state;
   spi_mode_t             mode_q;
   logic [DIV_WIDTH-1:0]  div_q;
   logic [SW-1:0]         ss_sel_q;
   logic [WORD_WIDTH-1:0] sreg;
   logic [WORD_WIDTH-1:0] shin_msb;
   logic [WORD_WIDTH-1:0] shin_lsb;
   logic [WORD_WIDTH-1:0] sreg_next;
   logic [LANE_WIDTH-1:0] beat_out;
   logic [CW-1:0]         edge_cnt;
   logic [SS_WIDTH-1:0]   ss_dec;
   logic                  tick, lead_edge, trail_edge;
   logic                  aborting, last_edge, sample, shift;

   assign start_ready_o = (state == IDLE);
   assign busy_o        = (state != IDLE);
   assign aborting      = abort_i && (state != IDLE);
   assign last_edge     = (edge_cnt == CW'(2 * N - 1));

   // CPHA=1 re-presents beat 0 on the first leading edge, so shifting is uniform.
   assign sample = mode_q.cpha ? trail_edge : lead_edge;
   assign shift  = mode_q.cpha ? lead_edge  : (trail_edge && !last_edge);

   generate
      if (WORD_WIDTH == LANE_WIDTH) begin : g_one_beat
         assign shin_msb = sd_i;
         assign shin_lsb = sd_i;
      end else begin : g_multi_beat
         assign shin_msb = {sreg[WORD_WIDTH-LANE_WIDTH-1:0], sd_i};
         assign shin_lsb = {sd_i, sreg[WORD_WIDTH-1:LANE_WIDTH]};
      end
   endgenerate

   assign sreg_next = mode_q.lsb_first ? shin_lsb : shin_msb;
   assign beat_out  = mode_q.lsb_first ? sreg[LANE_WIDTH-1:0]
                                       : sreg[WORD_WIDTH-1 -: LANE_WIDTH];

   spi_clk_gen #(
      .DIV_WIDTH (DIV_WIDTH)
   ) u_clk_gen (
      .clk        (clk),
      .reset      (reset),
      .load       (state == IDLE),
      .div        ((state == IDLE) ? div_i : div_q),
      .run        (state == XFER),
      .park       ((state == IDLE) || aborting),
      .idle_lvl   (cpol_i),
      .cpol       (mode_q.cpol),
      .tick       (tick),
      .lead_edge  (lead_edge),
      .trail_edge (trail_edge),
      .sclk       (sclk_o)
   );

   tree_decoder #(
      .SEL_WIDTH (SW),
      .OUT_WIDTH (SS_WIDTH)
   ) u_ss_dec (
      .en  ((state != IDLE) || start_valid_i),
      .sel ((state == IDLE) ? ss_sel_i : ss_sel_q),
      .dec (ss_dec)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         mode_q    <= '0;
         div_q     <= '0;
         ss_sel_q  <= '0;
         sreg      <= '0;
         edge_cnt  <= '0;
         sd_o      <= '0;
         ss_o      <= '0;
         rx_data_o <= '0;
         done_o    <= 1'b0;
      end else begin
         done_o <= 1'b0;
         if (aborting) begin
            state <= IDLE;
            ss_o  <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start_valid_i) begin
                     mode_q.cpol      <= cpol_i;
                     mode_q.cpha      <= cpha_i;
                     mode_q.lsb_first <= lsb_first_i;
                     div_q            <= div_i;
                     ss_sel_q         <= ss_sel_i;
                     sreg             <= tx_data_i;
                     sd_o             <= lsb_first_i ? tx_data_i[LANE_WIDTH-1:0]
                                                     : tx_data_i[WORD_WIDTH-1 -: LANE_WIDTH];
                     ss_o             <= ss_dec;
                     edge_cnt         <= '0;
                     state            <= SETUP;
                  end
               end
               SETUP: begin
                  if (tick) state <= XFER;
               end
               XFER: begin
                  if (lead_edge || trail_edge) begin
                     edge_cnt <= edge_cnt + 1'b1;
                     if (sample)    sreg  <= sreg_next;
                     if (shift)     sd_o  <= beat_out;
                     if (last_edge) state <= HOLD;
                  end
               end
               HOLD: begin
                  if (tick) begin
                     state     <= IDLE;
                     rx_data_o <= sreg;
                     done_o    <= 1'b1;
                     ss_o      <= '0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- System-clocked SPI master. Generates SCLK from `clk` through a programmable divider.
- Supports all four CPOL/CPHA modes, MSB- or LSB-first bit order, and multi-lane transfers (LANE_WIDTH bits per SCLK beat).
- Drives one-hot active-high slave selects with setup and hold guard intervals.
- Sits between a bus-side register block (valid/ready command port) and the pads. It replaces the raw SCLK-clocked shifter with a fully synchronous master.

Parameters:
- WORD_WIDTH, 8, bits per transfer; must be a multiple of LANE_WIDTH.
- LANE_WIDTH, 1, data lanes per direction (1 = standard, 2 = dual, 4 = quad).
- SS_WIDTH, 1, number of slave-select outputs.
- DIV_WIDTH, 8, width of the clock-divider setting.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-high reset.
- start_valid_i, in, 1, transfer request.
- start_ready_o, out, 1, high only in IDLE; a transfer is accepted when start_valid_i & start_ready_o.
- tx_data_i, in, WORD_WIDTH, word to send; latched on accept.
- ss_sel_i, in, $clog2(max(SS_WIDTH,2)), slave index; latched on accept.
- cpol_i, in, 1, clock polarity; quasi-static.
- cpha_i, in, 1, clock phase; latched on accept.
- lsb_first_i, in, 1, bit order; latched on accept.
- div_i, in, DIV_WIDTH, half-period = div_i+1 clk cycles; latched on accept.
- abort_i, in, 1, cancel the active transfer.
- rx_data_o, out, WORD_WIDTH, last completed received word.
- done_o, out, 1, one-cycle pulse on completion.
- busy_o, out, 1, state != IDLE.
- sclk_o, out, 1, SPI clock.
- ss_o, out, SS_WIDTH, one-hot active-high slave select.
- sd_o, out, LANE_WIDTH, MOSI lanes.
- sd_i, in, LANE_WIDTH, MISO lanes.

Behaviour:

Reset (async, all registered):
- State = IDLE.
- sclk_o = 0, ss_o = 0, sd_o = 0, rx_data_o = 0, done_o = 0, busy_o = 0.
- start_ready_o = 1 after reset release.

Timing base:
- h = div_i+1 cycles per half-period.
- N = WORD_WIDTH/LANE_WIDTH beats per transfer.
- A half-period counter reloads at each state or edge event.

IDLE:
- sclk_o is registered from cpol_i every cycle.
- ss_o = 0.
- On accept: latch all transfer inputs, load the shift register with tx_data_i, go to SETUP.

SETUP (h cycles):
- ss_o = one-hot(ss_sel) via tree_decoder, decoder enabled outside IDLE.
- sd_o presents the first beat.
- Then go to XFER.

XFER (2N half-periods):
- sclk_o toggles at the end of each half-period. The leading edge is the first toggle away from CPOL.
- CPHA=0: sample sd_i on leading edges; shift out the next beat on trailing edges, except the last.
- CPHA=1: shift out on leading edges (the first leading edge presents beat 0; sd_o in SETUP is don't-care but driven to beat 0); sample on trailing edges.
- After the 2N-th toggle, sclk_o equals CPOL. Go to HOLD.

Bit order:
- MSB-first: sd_o = sreg[W-1 -: L]; sample sreg <= {sreg[W-L-1:0], sd_i}. When L == W, sreg <= sd_i.
- LSB-first: sd_o = sreg[L-1:0]; sample sreg <= {sd_i, sreg[W-1:L]}.
- Lane L-1 is the most significant lane in both orders.

HOLD (h cycles):
- ss_o stays asserted; sclk_o = CPOL.
- Then go to IDLE. In the same edge: rx_data_o <= sreg, done_o <= 1 for one cycle, ss_o <= 0.

Latency:
- done_o is high in the cycle following clock edge accept + (2N+2)*h.
- Example: N=8, h=1 gives 18 cycles.

Abort:
- abort_i high in any non-IDLE state: next edge goes to IDLE.
- ss_o = 0, sclk_o = cpol_i, no done_o, rx_data_o unchanged.
- abort_i in IDLE is ignored; start is accepted normally.

Back-to-back:
- start_ready_o rises in the cycle done_o pulses. A new request may be accepted at that edge.
- Minimum SS-low gap is 1 cycle.

Input stability:
- A cpol_i change while busy has no effect until IDLE.
- Changes to tx_data_i, div_i and ss_sel_i after accept have no effect.

Selects:
- ss_sel_i >= SS_WIDTH: decoder output all-zero. The transfer still runs (SCLK toggles, no slave selected).

Width rules:
- The divider counter is DIV_WIDTH bits. The beat counter is $clog2(2N+1) bits.
- Elaboration-time error if WORD_WIDTH % LANE_WIDTH != 0.

Decomposition:
- Package spi_pkg:
  - spi_state_t enum {IDLE, SETUP, XFER, HOLD}.
  - spi_mode_t struct {cpol, cpha, lsb_first}.
  - Function for the beat count.
- Sub-module spi_clk_gen: half-period counter and SCLK toggle. Outputs lead_edge/trail_edge strobes and a half-period tick; restarts on a load input.
- Existing tree_decoder generates ss_o.

Test Plan:
1. W=8, L=1, div=0, mode 0, MSB-first, tx=0xA5, sd_i looped to sd_o -> rx_data_o=0xA5, done_o 18 cycles after accept, 8 rising SCLK edges, ss_o=1 throughout.
2. Modes 1/2/3, div=3, tx=0x3C, slave model returning 0xC3 -> rx=0xC3 in each mode; SCLK idles at CPOL; sampling edge matches CPHA; done_o 72 cycles after accept.
3. LSB-first, tx=0x01 -> first sd_o beat 1, remaining 0; slave returns bits 1,0,0,0,0,0,0,0 in time order -> rx=0x01.
4. W=16, L=4, SS_WIDTH=4, ss_sel=2, tx=0x1234 -> sd_o beats 1,2,3,4; ss_o=4'b0100; 4 SCLK pulses; loopback rx=0x1234.
5. abort_i asserted at the 5th SCLK edge -> next cycle ss_o=0, state IDLE, no done_o, rx_data_o keeps its previous value; reset asserted mid-XFER -> all outputs at reset values immediately.
6. start_valid_i held high for two words -> second accept on the done_o cycle; SS low exactly 1 cycle between transfers; start_valid_i with abort_i in IDLE -> accepted.
